udma_adc_ts_cfg_master: RTL and testbench



---
 rtl/udma_adc_ts_cfg_pkg.sv | 40 ++++
 rtl/udma_adc_ts_cfg_if.sv | 15 +
 rtl/udma_adc_ts_poll_timer.sv | 25 ++
 rtl/udma_adc_ts_cfg_master.sv | 203 ++++++++++++++++++++
 tb/tb_udma_adc_ts_cfg_master.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/udma_adc_ts_cfg_pkg.sv
// udma_adc_ts_cfg_pkg
// Shared definitions for the uDMA ADC timestamp cfg-bus initiator:
// register word addresses, CFG register bit positions, FSM state encoding
// and the packed bus-request record decoded by the master FSM.
// Ports: none (package).
package udma_adc_ts_cfg_pkg;

   localparam logic [4:0] REG_SADDR = 5'h00;
   localparam logic [4:0] REG_SIZE  = 5'h01;
   localparam logic [4:0] REG_CFG   = 5'h02;
   localparam logic [4:0] REG_PEND  = 5'h04;

   localparam int unsigned CFG_CLR_BIT  = 5;
   localparam int unsigned CFG_EN_BIT   = 4;
   localparam int unsigned CFG_CONT_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_SADDR,
      ST_WR_SIZE,
      ST_WR_CFG,
      ST_POLL_WAIT,
      ST_RD_PEND,
      ST_RD_CFG,
      ST_WR_CLR
   } state_e;

   typedef struct packed {
      logic        valid;
      logic        rwn;
      logic [4:0]  addr;
      logic [31:0] data;
   } cfg_req_t;

   // States that present a request on the cfg bus.
   function automatic logic is_access(state_e s);
      return (s != ST_IDLE) && (s != ST_POLL_WAIT);
   endfunction

endpackage

// File: rtl/udma_adc_ts_cfg_if.sv
// udma_adc_ts_cfg_if
// Cfg-bus between the timestamp-channel initiator and its responder.
// Signals: valid/rwn/addr/wdata driven by the master; rdata/ready by the
// slave. rdata is only meaningful in the handshake cycle (valid & ready).
interface udma_adc_ts_cfg_if;
   logic        valid;
   logic        rwn;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output valid, rwn, addr, wdata, input rdata, ready);
   modport slave  (input valid, rwn, addr, wdata, output rdata, ready);
endinterface

// File: rtl/udma_adc_ts_poll_timer.sv
// udma_adc_ts_poll_timer
// Loadable down-counter that stops at zero.
// Ports: clk_i, rst_i (sync, active-high), load_i (load load_val_i this
// edge), load_val_i, zero_o (count is 0).
module udma_adc_ts_poll_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)              cnt_q <= '0;
      else if (load_i)        cnt_q <= load_val_i;
      else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/udma_adc_ts_cfg_master.sv
// udma_adc_ts_cfg_master
// Cfg-bus initiator for the uDMA ADC timestamp channel. A start command
// writes SADDR, SIZE and CFG, then PEND is polled every POLL_CYCLES clocks;
// polled counts accumulate (saturating) into evt_total_o and the CFG en/pend
// bits are mirrored. A stop command clears the channel and drains PEND once.
// Ports: clk_i, rst_i (sync, active-high); cmd_* one-beat command handshake;
// cfg (udma_adc_ts_cfg_if.master) register bus; busy_o/done_o FSM status;
// evt_total_o/evt_delta_o/evt_valid_o poll results; stat_en_o/stat_pend_o
// mirrored CFG bits; err_o bus timeout pulse.
// Optional feature macro: ADC_TS_CFG_TIMEOUT_EN (16-cycle bus watchdog).
module udma_adc_ts_cfg_master
   import udma_adc_ts_cfg_pkg::*;
#(
   parameter int L2_AWIDTH_NOAL = 12,
   parameter int TRANS_SIZE     = 16,
   parameter int POLL_CYCLES    = 256,
   parameter int ACC_WIDTH      = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_start_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cmd_saddr_i,
   input  logic [TRANS_SIZE-1:0]     cmd_size_i,
   input  logic                      cmd_continuous_i,
   output logic                      busy_o,
   output logic                      done_o,
   udma_adc_ts_cfg_if.master         cfg,
   output logic [ACC_WIDTH-1:0]      evt_total_o,
   output logic [TRANS_SIZE-3:0]     evt_delta_o,
   output logic                      evt_valid_o,
   output logic                      stat_en_o,
   output logic                      stat_pend_o,
   output logic                      err_o
);

   localparam int TW = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;

   state_e                      state_q, state_d;
   cfg_req_t                    req;
   logic [L2_AWIDTH_NOAL-1:0]   saddr_q;
   logic [TRANS_SIZE-1:0]       size_q;
   logic                        cont_q, stop_q;
   logic [ACC_WIDTH-1:0]        total_q;
   logic [TRANS_SIZE-3:0]       delta_q, pend_cnt;
   logic [ACC_WIDTH:0]          acc_sum;
   logic                        evt_valid_q, done_q, stat_en_q, stat_pend_q;
   logic                        hs, tmr_zero, tmr_load, timeout, start_acc;
   logic                        rdata_unused;

   assign hs        = req.valid & cfg.ready;
   assign start_acc = (state_q == ST_IDLE) & cmd_valid_i & cmd_start_i;
   assign pend_cnt  = cfg.rdata[TRANS_SIZE-3:0];
   assign acc_sum   = {1'b0, total_q} + {{(ACC_WIDTH+3-TRANS_SIZE){1'b0}}, pend_cnt};
   assign rdata_unused = ^cfg.rdata;

`ifdef ADC_TS_CFG_TIMEOUT_EN
   // Counts consecutive stalled request cycles; any handshake or leaving the
   // access states clears it.
   logic       stall;
   logic [3:0] wdog_q;
   logic       err_q;

   assign stall   = is_access(state_q) & ~cfg.ready;
   assign timeout = stall & (wdog_q == 4'hF);

   always_ff @(posedge clk_i) begin
      if (rst_i || !stall) wdog_q <= '0;
      else                 wdog_q <= wdog_q + 1'b1;
      if (rst_i)           err_q  <= 1'b0;
      else                 err_q  <= timeout;
   end
   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Timer is reloaded on every entry into POLL_WAIT so the poll interval is
   // measured from the end of the previous access.
   assign tmr_load = (state_d == ST_POLL_WAIT) && (state_q != ST_POLL_WAIT);

   udma_adc_ts_poll_timer #(.W(TW)) u_poll_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (tmr_load),
      .load_val_i (TW'(POLL_CYCLES-1)),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req         = '0;
      cmd_ready_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (start_acc) state_d = ST_WR_SADDR;
         end
         ST_WR_SADDR: begin
            req = '{valid: 1'b1, rwn: 1'b0, addr: REG_SADDR, data: 32'(saddr_q)};
            if (cfg.ready) state_d = ST_WR_SIZE;
         end
         ST_WR_SIZE: begin
            req = '{valid: 1'b1, rwn: 1'b0, addr: REG_SIZE, data: 32'(size_q)};
            if (cfg.ready) state_d = ST_WR_CFG;
         end
         ST_WR_CFG: begin
            req.valid              = 1'b1;
            req.addr               = REG_CFG;
            req.data[CFG_EN_BIT]   = 1'b1;
            req.data[CFG_CONT_BIT] = cont_q;
            if (cfg.ready) state_d = ST_POLL_WAIT;
         end
         ST_POLL_WAIT: begin
            cmd_ready_o = ~cmd_start_i;
            // Stop takes priority over an expiring poll timer.
            if (cmd_valid_i && !cmd_start_i) state_d = ST_WR_CLR;
            else if (tmr_zero)               state_d = ST_RD_PEND;
         end
         ST_RD_PEND: begin
            req.valid = 1'b1;
            req.rwn   = 1'b1;
            req.addr  = REG_PEND;
            if (cfg.ready) state_d = stop_q ? ST_IDLE : ST_RD_CFG;
         end
         ST_RD_CFG: begin
            req.valid = 1'b1;
            req.rwn   = 1'b1;
            req.addr  = REG_CFG;
            if (cfg.ready) begin
               if (!cont_q && !cfg.rdata[CFG_EN_BIT] && !cfg.rdata[CFG_CLR_BIT])
                  state_d = ST_IDLE;
               else
                  state_d = ST_POLL_WAIT;
            end
         end
         ST_WR_CLR: begin
            req.valid             = 1'b1;
            req.addr              = REG_CFG;
            req.data[CFG_CLR_BIT] = 1'b1;
            if (cfg.ready) state_d = ST_RD_PEND;
         end
         default: state_d = ST_IDLE;
      endcase
      if (timeout) state_d = ST_IDLE;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         saddr_q     <= '0;
         size_q      <= '0;
         cont_q      <= 1'b0;
         stop_q      <= 1'b0;
         total_q     <= '0;
         delta_q     <= '0;
         evt_valid_q <= 1'b0;
         done_q      <= 1'b0;
         stat_en_q   <= 1'b0;
         stat_pend_q <= 1'b0;
      end else begin
         evt_valid_q <= 1'b0;
         done_q      <= (state_d == ST_IDLE) && (state_q != ST_IDLE);
         if (start_acc) begin
            saddr_q <= cmd_saddr_i;
            size_q  <= cmd_size_i;
            cont_q  <= cmd_continuous_i;
            stop_q  <= 1'b0;
            total_q <= '0;
            delta_q <= '0;
         end
         if (state_q == ST_WR_CLR) stop_q <= 1'b1;
         if (hs && state_q == ST_RD_PEND) begin
            delta_q     <= pend_cnt;
            total_q     <= acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
            evt_valid_q <= |pend_cnt;
         end
         if (hs && state_q == ST_RD_CFG) begin
            stat_en_q   <= cfg.rdata[CFG_EN_BIT];
            stat_pend_q <= cfg.rdata[CFG_CLR_BIT];
         end
      end
   end

   assign cfg.valid   = req.valid;
   assign cfg.rwn     = req.rwn;
   assign cfg.addr    = req.addr;
   assign cfg.wdata   = req.data;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;
   assign evt_total_o = total_q;
   assign evt_delta_o = delta_q;
   assign evt_valid_o = evt_valid_q;
   assign stat_en_o   = stat_en_q;
   assign stat_pend_o = stat_pend_q;

endmodule

// File: tb/tb_udma_adc_ts_cfg_master.sv
// tb_udma_adc_ts_cfg_master
// Directed bench: a cycle table for start / poll / stop, then hand-written
// sequences for back-pressure, self-termination, saturation, long stall
// (or timeout when ADC_TS_CFG_TIMEOUT_EN is defined) and mid-transfer reset.
module tb_udma_adc_ts_cfg_master;
   localparam int AW = 12, TS = 16, PC = 4, ACW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, cmd_valid, cmd_ready, cmd_start, cmd_cont;
   logic [AW-1:0] cmd_saddr;
   logic [TS-1:0] cmd_size;
   logic busy, done, err, evt_valid, stat_en, stat_pend;
   logic [ACW-1:0] evt_total;
   logic [TS-3:0]  evt_delta;
   logic rdy;
   logic [31:0] pend_val, cfg_val;

   udma_adc_ts_cfg_if cfg_if ();
   assign cfg_if.ready = rdy;
   assign cfg_if.rdata = (cfg_if.addr == 5'h04) ? pend_val : cfg_val;

   udma_adc_ts_cfg_master #(
      .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .POLL_CYCLES(PC), .ACC_WIDTH(ACW)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_start_i(cmd_start),
      .cmd_saddr_i(cmd_saddr), .cmd_size_i(cmd_size), .cmd_continuous_i(cmd_cont),
      .busy_o(busy), .done_o(done), .cfg(cfg_if),
      .evt_total_o(evt_total), .evt_delta_o(evt_delta), .evt_valid_o(evt_valid),
      .stat_en_o(stat_en), .stat_pend_o(stat_pend), .err_o(err)
   );

   int n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_bus(input string nm, input logic v, input logic r,
                          input logic [4:0] a, input logic [31:0] d);
      chk({nm, " valid"}, 32'(cfg_if.valid), 32'(v));
      if (v) begin
         chk({nm, " rwn"},  32'(cfg_if.rwn),  32'(r));
         chk({nm, " addr"}, 32'(cfg_if.addr), 32'(a));
         chk({nm, " data"}, cfg_if.wdata, d);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   typedef struct {
      logic cv, cs;
      logic [31:0] pend, cfgr;
      logic ecr, ebusy, edone, evld, erwn;
      logic [4:0] eaddr;
      logic [31:0] edata;
      logic [15:0] etot;
      logic eev;
   } vec_t;
   vec_t tv[$];

   function automatic void add(input logic cv, cs, input logic [31:0] pend, cfgr,
                               input logic ecr, ebusy, edone, evld, erwn,
                               input logic [4:0] eaddr, input logic [31:0] edata,
                               input logic [15:0] etot, input logic eev);
      vec_t v;
      v = '{cv, cs, pend, cfgr, ecr, ebusy, edone, evld, erwn, eaddr, edata, etot, eev};
      tv.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic found;
      logic [15:0] sat_exp [6];
      sat_exp = '{16'h3FFF, 16'h7FFE, 16'hBFFD, 16'hFFFC, 16'hFFFF, 16'hFFFF};

      // Start/poll/stop cycle table (saddr 340, size 100, continuous, ready=1).
      add(1,1,0,0,       1,0,0,0,0,5'h0,32'h0,  16'd0, 0); // c0 start accepted
      add(0,0,0,0,       0,1,0,1,0,5'h0,32'h340,16'd0, 0); // SADDR
      add(0,0,0,0,       0,1,0,1,0,5'h1,32'h100,16'd0, 0); // SIZE
      add(0,0,0,0,       0,1,0,1,0,5'h2,32'h11, 16'd0, 0); // CFG
      for (int i = 0; i < 4; i++) add(0,0,0,0, 1,1,0,0,0,5'h0,32'h0,16'd0,0);
      add(0,0,5,0,       0,1,0,1,1,5'h4,32'h0,  16'd0, 0); // c8 RD_PEND=5
      add(0,0,0,32'h10,  0,1,0,1,1,5'h2,32'h0,  16'd5, 1); // RD_CFG
      for (int i = 0; i < 4; i++) add(0,0,0,0, 1,1,0,0,0,5'h0,32'h0,16'd5,0);
      add(0,0,0,0,       0,1,0,1,1,5'h4,32'h0,  16'd5, 0); // RD_PEND=0
      add(0,0,0,32'h10,  0,1,0,1,1,5'h2,32'h0,  16'd5, 0);
      for (int i = 0; i < 4; i++) add(0,0,0,0, 1,1,0,0,0,5'h0,32'h0,16'd5,0);
      add(0,0,3,0,       0,1,0,1,1,5'h4,32'h0,  16'd5, 0); // RD_PEND=3
      add(0,0,0,32'h30,  0,1,0,1,1,5'h2,32'h0,  16'd8, 1);
      for (int i = 0; i < 3; i++) add(1,1,0,0, 0,1,0,0,0,5'h0,32'h0,16'd8,0); // start stalled
      add(1,0,0,0,       1,1,0,0,0,5'h0,32'h0,  16'd8, 0); // stop as timer hits 0
      add(0,0,0,0,       0,1,0,1,0,5'h2,32'h20, 16'd8, 0); // WR_CLR
      add(0,0,2,0,       0,1,0,1,1,5'h4,32'h0,  16'd8, 0); // drain PEND=2
      add(0,0,0,0,       1,0,1,0,0,5'h0,32'h0,  16'd10,1); // IDLE, done
      add(0,0,0,0,       1,0,0,0,0,5'h0,32'h0,  16'd10,0);

      rst = 1'b1; cmd_valid = 0; cmd_start = 0; cmd_cont = 1;
      cmd_saddr = 12'h340; cmd_size = 16'h0100; rdy = 1; pend_val = 0; cfg_val = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0; #1;
      chk("rst cmd_ready", 32'(cmd_ready), 1);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst valid", 32'(cfg_if.valid), 0);
      chk("rst total", 32'(evt_total), 0);
      chk("rst evt_valid", 32'(evt_valid), 0);
      chk("rst err", 32'(err), 0);
      chk("rst stat_en", 32'(stat_en), 0);

      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         cmd_valid = tv[i].cv; cmd_start = tv[i].cs;
         pend_val = tv[i].pend; cfg_val = tv[i].cfgr;
         #1;
         chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'(tv[i].ecr));
         chk($sformatf("v%0d busy", i), 32'(busy), 32'(tv[i].ebusy));
         chk($sformatf("v%0d done", i), 32'(done), 32'(tv[i].edone));
         chk_bus($sformatf("v%0d", i), tv[i].evld, tv[i].erwn, tv[i].eaddr, tv[i].edata);
         chk($sformatf("v%0d total", i), 32'(evt_total), 32'(tv[i].etot));
         chk($sformatf("v%0d evt_valid", i), 32'(evt_valid), 32'(tv[i].eev));
      end
      chk("seq1 delta", 32'(evt_delta), 32'd2);
      chk("seq1 stat_en", 32'(stat_en), 1);
      chk("seq1 stat_pend", 32'(stat_pend), 1);

      // Back-pressure on WR_SIZE, then self-termination (continuous = 0).
      cmd_saddr = 12'h0AB; cmd_size = 16'h0040; cmd_cont = 0;
      pend_val = 0; cfg_val = 0;
      @(negedge clk); cmd_valid = 1; cmd_start = 1; #1;
      chk("bp cmd_ready", 32'(cmd_ready), 1);
      cyc(); cmd_valid = 0; cmd_start = 0;
      chk_bus("bp saddr", 1, 0, 5'h0, 32'h0AB);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); rdy = (k == 3); #1;
         chk_bus($sformatf("bp size%0d", k), 1, 0, 5'h1, 32'h40);
      end
      cyc(); chk_bus("bp cfg", 1, 0, 5'h2, 32'h10);
      for (int k = 0; k < 4; k++) begin
         cyc(); chk($sformatf("bp poll%0d valid", k), 32'(cfg_if.valid), 0);
      end
      cyc(); chk_bus("st rd_pend", 1, 1, 5'h4, 32'h0);
      cyc(); chk_bus("st rd_cfg", 1, 1, 5'h2, 32'h0);
      cyc();
      chk("st done", 32'(done), 1);
      chk("st busy", 32'(busy), 0);
      chk("st stat_en", 32'(stat_en), 0);
      chk("st stat_pend", 32'(stat_pend), 0);
      chk("st total", 32'(evt_total), 0);
      chk("st evt_valid", 32'(evt_valid), 0);

      // Saturation of the 16-bit accumulator with repeated 3FFF polls.
      cmd_cont = 1; pend_val = 32'h3FFF; cfg_val = 32'h10;
      @(negedge clk); cmd_valid = 1; cmd_start = 1; #1;
      cyc(); cmd_valid = 0; cmd_start = 0;
      for (int p = 0; p < 6; p++) begin
         found = 0;
         for (int w = 0; w < 30 && !found; w++) begin
            cyc();
            if (cfg_if.valid && cfg_if.rwn && cfg_if.addr == 5'h02) found = 1;
         end
         chk($sformatf("sat%0d reached", p), 32'(found), 1);
         chk($sformatf("sat%0d total", p), 32'(evt_total), 32'(sat_exp[p]));
      end
      @(negedge clk); cmd_valid = 1; cmd_start = 0; #1;
      chk("sat stop ready", 32'(cmd_ready), 1);
      cyc(); cmd_valid = 0;
      chk_bus("sat clr", 1, 0, 5'h2, 32'h20);
      found = 0;
      for (int w = 0; w < 10 && !found; w++) begin
         cyc();
         if (done) found = 1;
      end
      chk("sat done seen", 32'(found), 1);
      chk("sat total final", 32'(evt_total), 32'hFFFF);
      chk("sat delta", 32'(evt_delta), 32'h3FFF);
      // Stop while idle: acknowledged, nothing else.
      @(negedge clk); cmd_valid = 1; cmd_start = 0; #1;
      chk("idle stop ready", 32'(cmd_ready), 1);
      cyc(); cmd_valid = 0;
      chk("idle stop busy", 32'(busy), 0);
      chk("idle stop done", 32'(done), 0);
      chk("idle stop valid", 32'(cfg_if.valid), 0);

      // Long stall on WR_SADDR.
      @(negedge clk); cmd_valid = 1; cmd_start = 1; rdy = 0; #1;
      cyc(); cmd_valid = 0; cmd_start = 0;
`ifdef ADC_TS_CFG_TIMEOUT_EN
      for (int k = 1; k < 16; k++) cyc();
      chk("to pre valid", 32'(cfg_if.valid), 1);
      chk("to pre err", 32'(err), 0);
      cyc();
      chk("to err", 32'(err), 1);
      chk("to done", 32'(done), 1);
      chk("to busy", 32'(busy), 0);
      chk("to valid", 32'(cfg_if.valid), 0);
      cyc();
      chk("to err pulse", 32'(err), 0);
      rdy = 1;
      @(negedge clk); cmd_valid = 1; cmd_start = 1; #1;
      cyc(); cmd_valid = 0; cmd_start = 0;
      cyc();
`else
      found = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (err) found = 1;
      end
      chk("stall err seen", 32'(found), 0);
      chk_bus("stall held", 1, 0, 5'h0, 32'h0AB);
      chk("stall busy", 32'(busy), 1);
      rdy = 1;
      cyc();
`endif
      // Reset in WR_SIZE: request drops next cycle, no clear write follows.
      chk_bus("mr size", 1, 0, 5'h1, 32'h40);
      rst = 1;
      cyc();
      chk("mr valid", 32'(cfg_if.valid), 0);
      chk("mr busy", 32'(busy), 0);
      chk("mr cmd_ready", 32'(cmd_ready), 1);
      chk("mr total", 32'(evt_total), 0);
      rst = 0;
      found = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (cfg_if.valid) found = 1;
      end
      chk("mr no traffic", 32'(found), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
